// File: rtl/pq_cmd_pacer.sv
// pq_cmd_pacer: buffers ENQ/DEQ/REPLACE commands and issues them to the heap PQ
// at a fixed minimum spacing. Define PQ_PACER_STATS_EN to add n_enq/n_deq/n_drop.
module pq_cmd_pacer #(
   parameter int KEY_WIDTH  = 8,
   parameter int VAL_WIDTH  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int OP_SPACE   = 4,
   parameter int PQ_CAP     = 15,
   localparam int KVW = KEY_WIDTH + VAL_WIDTH,
   localparam int CW  = $clog2(PQ_CAP + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [1:0]     s_op,
   input  logic [KVW-1:0] s_kv,
   output logic           pq_enq,
   output logic           pq_deq,
   output logic [KVW-1:0] pq_kvi,
   input  logic           pq_full,
   output logic [CW-1:0]  count,
   output logic           err_drop,
   output logic           busy
`ifdef PQ_PACER_STATS_EN
   ,
   output logic [15:0]    n_enq,
   output logic [15:0]    n_deq,
   output logic [15:0]    n_drop
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(OP_SPACE + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   localparam logic [1:0] OP_NOP = 2'd0;
   localparam logic [1:0] OP_ENQ = 2'd1;
   localparam logic [1:0] OP_DEQ = 2'd2;
   localparam logic [1:0] OP_REP = 2'd3;

   logic [1:0]     op_mem [FIFO_DEPTH];
   logic [KVW-1:0] kv_mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    fcnt;
   logic           fifo_full;
   logic           fifo_empty;
   logic           push;
   logic           pop;
   logic [1:0]     head_op;
   logic [KVW-1:0] head_kv;

   logic [1:0]     state;
   logic [GW-1:0]  gap_cnt;
   logic           room;
   logic           issue_enq;
   logic           issue_deq;
   logic           drop;

   assign fifo_full  = (fcnt == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (fcnt == '0);
   assign s_ready    = !fifo_full;
   assign push       = s_valid && s_ready;
   assign head_op    = op_mem[rd_ptr];
   assign head_kv    = kv_mem[rd_ptr];
   assign room       = (count != CW'(PQ_CAP)) && !pq_full;
   assign busy       = !fifo_empty || (state != IDLE);

   // Command storage: payload only, no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr] <= s_op;
         kv_mem[wr_ptr] <= s_kv;
      end
   end

   // FIFO pointers and fill level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fcnt <= fcnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Head decode: decide pop/issue/drop while idle
   always_comb begin
      pop       = 1'b0;
      issue_enq = 1'b0;
      issue_deq = 1'b0;
      drop      = 1'b0;
      if (state == IDLE && !fifo_empty) begin
         unique case (head_op)
            OP_NOP: pop = 1'b1;
            OP_ENQ: begin
               if (room) begin
                  pop       = 1'b1;
                  issue_enq = 1'b1;
               end
            end
            OP_DEQ: begin
               pop = 1'b1;
               if (count == '0) drop = 1'b1;
               else issue_deq = 1'b1;
            end
            OP_REP: begin
               pop       = 1'b1;
               issue_enq = 1'b1;
               issue_deq = (count != '0);
            end
         endcase
      end
   end

   // Spacing FSM: one strobe cycle then a gap of OP_SPACE-1 edges overall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (issue_enq || issue_deq) state <= ISSUE;
            end
            ISSUE: begin
               if (OP_SPACE == 1) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= GW'(OP_SPACE - 2);
                  state   <= GAP;
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt - GW'(1);
               if (gap_cnt <= GW'(1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered PQ strobes, payload and occupancy tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pq_enq   <= 1'b0;
         pq_deq   <= 1'b0;
         pq_kvi   <= '0;
         err_drop <= 1'b0;
         count    <= '0;
      end else begin
         pq_enq   <= issue_enq;
         pq_deq   <= issue_deq;
         err_drop <= drop;
         if (issue_enq) pq_kvi <= head_kv;
         if (issue_enq && !issue_deq) count <= count + CW'(1);
         else if (issue_deq && !issue_enq) count <= count - CW'(1);
      end
   end

`ifdef PQ_PACER_STATS_EN
   // Saturating operation statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_enq  <= '0;
         n_deq  <= '0;
         n_drop <= '0;
      end else begin
         if (issue_enq && n_enq != 16'hFFFF) n_enq <= n_enq + 16'd1;
         if (issue_deq && n_deq != 16'hFFFF) n_deq <= n_deq + 16'd1;
         if (drop && n_drop != 16'hFFFF) n_drop <= n_drop + 16'd1;
      end
   end
`endif

endmodule
